// File: rtl/joy_pad_reader.sv
// ----------------------------------------------------------------------------
// joy_pad_reader
//   CPU-bus controller port for two shared-protocol serial gamepads.
//   A poll strobes both pads, clocks out 16 bits from each and publishes the
//   decoded button state (1 = pressed) as four read-only byte registers.
//
//   Optional feature macro: JOY_PAD_READER_AUTOPOLL_EN
//     defined   -> free-running timer requests a poll every POLL_PERIOD cycles
//     undefined -> polls are started only by CPU writes
//
// Ports
//   i_clk_cpu, i_nRst        CPU clock, asynchronous active-low reset
//   i_ce, i_rnw, i_addr      bus select, read/not-write, register index
//   i_data_in                write data (value ignored; any write polls)
//   o_data_out               registered read data, 0xFF when not selected
//   o_joyN_strb, o_joyN_clk  pad latch strobe / shift clock (idle high)
//   i_joyN_data              asynchronous pad serial data, 0 = pressed
//   o_busy                   high from first strobe cycle through DONE
//   o_poll_done              one-cycle pulse during DONE
//
// Register map: 0 = pad1[7:0], 1 = pad1[15:8], 2 = pad2[7:0], 3 = pad2[15:8]
// ----------------------------------------------------------------------------
module joy_pad_reader #(
    parameter int unsigned CLK_DIV     = 6,
    parameter int unsigned POLL_PERIOD = 200000
) (
    input  logic       i_clk_cpu,
    input  logic       i_nRst,
    input  logic       i_ce,
    input  logic       i_rnw,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_data_in,
    output logic [7:0] o_data_out,
    output logic       o_joy1_strb,
    output logic       o_joy2_strb,
    output logic       o_joy1_clk,
    output logic       o_joy2_clk,
    input  logic       i_joy1_data,
    input  logic       i_joy2_data,
    output logic       o_busy,
    output logic       o_poll_done
);

    // Phase counter must reach 2*CLK_DIV-1 (509 at the largest legal CLK_DIV).
    localparam int unsigned DIV_W     = 9;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PAD_W     = 16;
    localparam int unsigned STRB_LEN  = 2 * CLK_DIV;
    localparam int unsigned PHASE_LEN = CLK_DIV;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAD_W-1:0]   shift1_q, shift1_d;
    logic [PAD_W-1:0]   shift2_q, shift2_d;
    logic [PAD_W-1:0]   pad1_q, pad1_d;
    logic [PAD_W-1:0]   pad2_q, pad2_d;
    logic               joy1_meta_q, joy1_sync_q;
    logic               joy2_meta_q, joy2_sync_q;
    logic               strb_q, strb_d;
    logic               jclk_q, jclk_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [7:0]         dout_q, dout_d;

    logic               write_req_c;
    logic               poll_req_c;
    logic               strb_last_c;
    logic               phase_last_c;
    logic [7:0]         reg_sel_c;

    // Write data carries no meaning; any write is a poll request.
    logic               data_in_unused;
    assign data_in_unused = ^i_data_in;

    assign write_req_c  = i_ce & ~i_rnw;
    assign strb_last_c  = (div_q == DIV_W'(STRB_LEN - 1));
    assign phase_last_c = (div_q == DIV_W'(PHASE_LEN - 1));

`ifdef JOY_PAD_READER_AUTOPOLL_EN
    localparam int unsigned TMR_W = $clog2(POLL_PERIOD);

    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               timer_expire_c;

    // Free-running period timer; restarts on expiry whether or not the poll is taken.
    assign timer_expire_c = (timer_q == TMR_W'(POLL_PERIOD - 1));
    assign timer_d        = timer_expire_c ? '0 : timer_q + TMR_W'(1);
    // A write and an expiry on the same edge merge into a single request.
    assign poll_req_c     = write_req_c | timer_expire_c;
`else
    localparam int unsigned POLL_PERIOD_UNUSED = POLL_PERIOD;

    assign poll_req_c = write_req_c;
`endif

    // Register file read mux.
    always_comb begin
        reg_sel_c = 8'hFF;
        case (i_addr)
            2'd0:    reg_sel_c = pad1_q[7:0];
            2'd1:    reg_sel_c = pad1_q[15:8];
            2'd2:    reg_sel_c = pad2_q[7:0];
            default: reg_sel_c = pad2_q[15:8];
        endcase
    end

    // Poll sequencer next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        shift1_d = shift1_q;
        shift2_d = shift2_q;
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;

        case (state_q)
            ST_IDLE: begin
                if (poll_req_c) begin
                    state_d = ST_STROBE;
                    cnt_d   = '0;
                    div_d   = '0;
                end
            end
            ST_STROBE: begin
                if (strb_last_c) begin
                    state_d = ST_SHIFT_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (phase_last_c) begin
                    shift1_d[cnt_q] = joy1_sync_q;
                    shift2_d[cnt_q] = joy2_sync_q;
                    state_d         = ST_SHIFT_LO;
                    div_d           = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT_LO: begin
                // The low phase after bit 15 completes the 16th clock pulse
                // before DONE, keeping the poll at 34*CLK_DIV cycles.
                if (phase_last_c) begin
                    div_d = '0;
                    if (cnt_q == CNT_W'(PAD_W - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_SHIFT_HI;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_DONE: begin
                // Pad lines are active-low; store 1 = pressed.
                pad1_d  = ~shift1_q;
                pad2_d  = ~shift2_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they toggle exactly on
        // the state transition and leave a flop cleanly.
        strb_d = (state_d == ST_STROBE);
        jclk_d = (state_d != ST_SHIFT_LO);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        // Read data reflects the registers before any DONE-cycle update.
        dout_d = (i_ce & i_rnw) ? reg_sel_c : 8'hFF;
    end

    // All state flops, including the two-stage pad data synchronizers.
    always_ff @(posedge i_clk_cpu or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            shift1_q    <= '0;
            shift2_q    <= '0;
            pad1_q      <= '0;
            pad2_q      <= '0;
            joy1_meta_q <= 1'b1;
            joy1_sync_q <= 1'b1;
            joy2_meta_q <= 1'b1;
            joy2_sync_q <= 1'b1;
            strb_q      <= 1'b0;
            jclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dout_q      <= 8'hFF;
`ifdef JOY_PAD_READER_AUTOPOLL_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            shift1_q    <= shift1_d;
            shift2_q    <= shift2_d;
            pad1_q      <= pad1_d;
            pad2_q      <= pad2_d;
            joy1_meta_q <= i_joy1_data;
            joy1_sync_q <= joy1_meta_q;
            joy2_meta_q <= i_joy2_data;
            joy2_sync_q <= joy2_meta_q;
            strb_q      <= strb_d;
            jclk_q      <= jclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dout_q      <= dout_d;
`ifdef JOY_PAD_READER_AUTOPOLL_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign o_data_out  = dout_q;
    assign o_joy1_strb = strb_q;
    assign o_joy2_strb = strb_q;
    assign o_joy1_clk  = jclk_q;
    assign o_joy2_clk  = jclk_q;
    assign o_busy      = busy_q;
    assign o_poll_done = done_q;

endmodule

// File: tb/tb_joy_pad_reader.sv
// ----------------------------------------------------------------------------
// tb_joy_pad_reader
//   Directed bench for joy_pad_reader with behavioural pads and a
//   cycle-level reference model of the poll timeline and register file.
//   Build with JOY_PAD_READER_AUTOPOLL_EN defined to exercise autopoll
//   (CLK_DIV=4, POLL_PERIOD=500); default build uses CLK_DIV=6.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_joy_pad_reader;

`ifdef JOY_PAD_READER_AUTOPOLL_EN
    localparam int D = 4;
    localparam int P = 500;
`else
    localparam int D = 6;
    localparam int P = 200000;
`endif
    localparam int POLL_LEN = 34 * D;   // cycles before DONE

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic       rnw = 1'b1;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       strb1, strb2, jclk1, jclk2, busy, done;
    logic       jd1, jd2;

    logic [15:0] pad1_bits = 16'h0000;  // 1 = pressed
    logic [15:0] pad2_bits = 16'h0000;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    joy_pad_reader #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
        .i_clk_cpu   (clk),
        .i_nRst      (rst_n),
        .i_ce        (ce),
        .i_rnw       (rnw),
        .i_addr      (addr),
        .i_data_in   (din),
        .o_data_out  (dout),
        .o_joy1_strb (strb1),
        .o_joy2_strb (strb2),
        .o_joy1_clk  (jclk1),
        .o_joy2_clk  (jclk2),
        .i_joy1_data (jd1),
        .i_joy2_data (jd2),
        .o_busy      (busy),
        .o_poll_done (done)
    );

    // Behavioural pads: strobe reloads, each rising clk presents the next bit.
    int idx1 = 0;
    int idx2 = 0;
    always @(posedge strb1 or posedge jclk1) begin
        if (strb1) idx1 = 0;
        else       idx1 = idx1 + 1;
    end
    always @(posedge strb2 or posedge jclk2) begin
        if (strb2) idx2 = 0;
        else       idx2 = idx2 + 1;
    end
    logic [3:0] i1, i2;
    assign i1  = idx1[3:0];
    assign i2  = idx2[3:0];
    assign jd1 = (idx1 < 16) ? ~pad1_bits[i1] : 1'b1;
    assign jd2 = (idx2 < 16) ? ~pad2_bits[i2] : 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mk = offset into the current poll (-1 when idle).
    int          mk = -1;
    int          m_n = 0;
    logic [15:0] m_pad1 = 16'h0000;
    logic [15:0] m_pad2 = 16'h0000;
    logic [7:0]  m_dout = 8'hFF;

    function automatic logic [7:0] m_byte(input logic [1:0] a, input logic [15:0] p1, input logic [15:0] p2);
        case (a)
            2'd0:    return p1[7:0];
            2'd1:    return p1[15:8];
            2'd2:    return p2[7:0];
            default: return p2[15:8];
        endcase
    endfunction

    function automatic logic m_strb(input int k);
        return (k >= 0) && (k < 2 * D);
    endfunction

    // Shift clock is low in every odd D-cycle slot after the strobe.
    function automatic logic m_clk(input int k);
        if (k < 2 * D || k >= POLL_LEN) return 1'b1;
        return (((k - 2 * D) / D) % 2) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic req;
        if (!rst_n) begin
            mk     = -1;
            m_n    = 0;
            m_pad1 = 16'h0000;
            m_pad2 = 16'h0000;
            m_dout = 8'hFF;
        end else begin
            m_n = m_n + 1;
            req = ce && !rnw;
`ifdef JOY_PAD_READER_AUTOPOLL_EN
            if (m_n % P == 0) req = 1'b1;
`endif
            m_dout = (ce && rnw) ? m_byte(addr, m_pad1, m_pad2) : 8'hFF;
            if (mk >= 0) begin
                if (mk == POLL_LEN) begin
                    m_pad1 = pad1_bits;
                    m_pad2 = pad2_bits;
                    mk     = -1;
                end else begin
                    mk = mk + 1;
                end
            end else if (req) begin
                mk = 0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_strb1", 32'(strb1), 32'(m_strb(mk)));
            chk("cyc_strb2", 32'(strb2), 32'(m_strb(mk)));
            chk("cyc_clk1",  32'(jclk1), 32'(m_clk(mk)));
            chk("cyc_clk2",  32'(jclk2), 32'(m_clk(mk)));
            chk("cyc_busy",  32'(busy),  32'(mk >= 0));
            chk("cyc_done",  32'(done),  32'(mk == POLL_LEN));
            chk("cyc_dout",  32'(dout),  32'(m_dout));
        end
    end

    int ecnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic cpu_write(input logic [1:0] a);
        ce = 1'b1; rnw = 1'b0; addr = a; din = 8'hA5;
        @(posedge clk); #1;
        ce = 1'b0; rnw = 1'b1;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
        ce = 1'b1; rnw = 1'b1; addr = a;
        @(posedge clk); #1;
        v  = dout;
        ce = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] v;
        cpu_read(a, v);
        chk(name, 32'(v), 32'(exp));
    endtask

    int ms_strb_hi, ms_rises, ms_runs, ms_min, ms_max, ms_done_at, ms_done_n, ms_busy;

    // Observe one poll window; cycle 0 is the cycle right after the write edge.
    task automatic measure(input int win, input int extra_at);
        logic prev_strb;
        int   run;
        prev_strb = 1'b0; run = 0;
        ms_strb_hi = 0; ms_rises = 0; ms_runs = 0; ms_min = 1000; ms_max = 0;
        ms_done_at = -1; ms_done_n = 0; ms_busy = 0;
        for (int c = 0; c < win; c++) begin
            if (strb1) ms_strb_hi++;
            if (strb1 && !prev_strb) ms_rises++;
            prev_strb = strb1;
            if (!jclk1) run++;
            else if (run > 0) begin
                ms_runs++;
                if (run < ms_min) ms_min = run;
                if (run > ms_max) ms_max = run;
                run = 0;
            end
            if (busy) ms_busy++;
            if (done) begin ms_done_at = c; ms_done_n++; end
            if (c == extra_at) begin ce = 1'b1; rnw = 1'b0; end
            else               begin ce = 1'b0; rnw = 1'b1; end
            @(posedge clk); #1;
        end
        ce = 1'b0; rnw = 1'b1;
    endtask

    // DONE is the 205th busy cycle (offset 34*D) counting the first strobe cycle.
    task automatic check_poll(input string tag);
        chk({tag, "_strb_len"},  32'(ms_strb_hi), 32'(2 * D));
        chk({tag, "_strb_rise"}, 32'(ms_rises),   32'd1);
        chk({tag, "_clk_pulses"}, 32'(ms_runs),   32'd16);
        chk({tag, "_low_min"},   32'(ms_min),     32'(D));
        chk({tag, "_low_max"},   32'(ms_max),     32'(D));
        chk({tag, "_done_at"},   32'(ms_done_at), 32'(POLL_LEN));
        chk({tag, "_done_n"},    32'(ms_done_n),  32'd1);
        chk({tag, "_busy_len"},  32'(ms_busy),    32'(POLL_LEN + 1));
    endtask

    initial begin
        logic [7:0] v;
        logic       seen;
        int         rise_t[4];
        int         nr;
        logic       pstrb;
        int         m;

        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_dout", 32'(dout), 32'hFF);
        chk("rst_strb", 32'(strb1), 32'd0);
        chk("rst_clk",  32'(jclk1), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        read_chk("rst_r0", 2'd0, 8'h00);
        read_chk("rst_r1", 2'd1, 8'h00);
        read_chk("rst_r2", 2'd2, 8'h00);
        read_chk("rst_r3", 2'd3, 8'h00);

`ifndef JOY_PAD_READER_AUTOPOLL_EN
        // First poll: pad1 0x5AC3, pad2 idle
        pad1_bits = 16'h5AC3; pad2_bits = 16'h0000;
        cpu_write(2'd0);
        chk("wr_latency", 32'(strb1), 32'd1);
        measure(POLL_LEN + 40, -1);
        check_poll("p1");
        read_chk("p1_r0", 2'd0, 8'hC3);
        read_chk("p1_r1", 2'd1, 8'h5A);
        read_chk("p1_r2", 2'd2, 8'h00);
        read_chk("p1_r3", 2'd3, 8'h00);

        // Write while busy is dropped
        cpu_write(2'd2);
        measure(POLL_LEN + 40, 50);
        check_poll("busy_wr");

        // Reset during a low clock phase
        pad1_bits = 16'hFFFF; pad2_bits = 16'hFFFF;
        cpu_write(2'd1);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (!jclk1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("lo_seen", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_clk",  32'(jclk1), 32'd1);
        chk("mrst_strb", 32'(strb1), 32'd0);
        chk("mrst_busy", 32'(busy),  32'd0);
        chk("mrst_dout", 32'(dout),  32'hFF);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        read_chk("mrst_r0", 2'd0, 8'h00);
        read_chk("mrst_r1", 2'd1, 8'h00);
        read_chk("mrst_r3", 2'd3, 8'h00);
        pad1_bits = 16'h5AC3; pad2_bits = 16'h0000;
        cpu_write(2'd3);
        measure(POLL_LEN + 40, -1);
        check_poll("fresh");
        read_chk("fresh_r1", 2'd1, 8'h5A);

        // Read coinciding with DONE returns the old byte
        pad1_bits = 16'h3C77; pad2_bits = 16'hA5F0;
        cpu_write(2'd0);
        repeat (POLL_LEN) begin @(posedge clk); #1; end
        chk("dr_done", 32'(done), 32'd1);
        ce = 1'b1; rnw = 1'b1; addr = 2'd1;
        @(posedge clk); #1;
        chk("dr_old", 32'(dout), 32'h5A);
        @(posedge clk); #1;
        chk("dr_new", 32'(dout), 32'h3C);
        ce = 1'b0;
        read_chk("p3_r0", 2'd0, 8'h77);
        read_chk("p3_r2", 2'd2, 8'hF0);
        read_chk("p3_r3", 2'd3, 8'hA5);
`else
        // Autopoll: strobe rises every P cycles without CPU writes
        pad1_bits = 16'h5AC3; pad2_bits = 16'h0000;
        nr = 0; pstrb = strb1;
        while (ecnt < 3 * P + 100) begin
            if (strb1 && !pstrb && nr < 4) begin rise_t[nr] = ecnt; nr++; end
            pstrb = strb1;
            @(posedge clk); #1;
        end
        chk("ap_rises", 32'(nr), 32'd3);
        chk("ap_first", 32'(rise_t[0]), 32'(P));
        chk("ap_gap1",  32'(rise_t[1] - rise_t[0]), 32'(P));
        chk("ap_gap2",  32'(rise_t[2] - rise_t[1]), 32'(P));
        read_chk("ap_r0", 2'd0, 8'hC3);
        read_chk("ap_r1", 2'd1, 8'h5A);
        read_chk("ap_r2", 2'd2, 8'h00);

        // Write on the same edge as the timer expiry yields one poll
        m = (ecnt / P + 1) * P;
        for (int c = 0; c < P + 10 && ecnt != m - 1; c++) begin
            @(posedge clk); #1;
        end
        chk("co_align", 32'(ecnt), 32'(m - 1));
        cpu_write(2'd0);
        chk("co_strb", 32'(strb1), 32'd1);
        measure(POLL_LEN + 40, -1);
        check_poll("co");
`endif

        repeat (4) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
